tbird_input_cond: RTL and testbench
===================================

# tbird_input_cond

Input conditioner in front of the Thunderbird tail-light sequencer. It synchronizes and debounces the raw left and right turn switches. It pairs near-simultaneous presses into a single hazard request, then issues exactly one request pulse per press on the `left`/`right` lines the sequencer samples. A switch must be released before it can issue another request, so switch bounce or a long hold never restarts a sequence mid-flash.

## Interface
- `DEBOUNCE_CYCLES`, default 4: consecutive stable cycles required before the debounced level changes (≥1).
- `PAIR_WINDOW`, default 8: cycles after a first press during which a press of the other switch makes the request a hazard (≥1).
- `REPEAT_CYCLES`, default 64: auto-repeat period; used only when `TBIRD_AUTOREPEAT_EN` is defined.
- `clk` in 1: single clock; all state is on its rising edge.
- `reset` in 1: asynchronous, active-low reset.
- `left_raw` in 1: raw left switch, asynchronous to `clk`.
- `right_raw` in 1: raw right switch, asynchronous to `clk`.
- `left` out 1: one-cycle left request to the sequencer.
- `right` out 1: one-cycle right request to the sequencer.
- `hazard` out 1: high in the same cycle as `left`&`right` when the request was paired.
- `busy` out 1: high in any state other than IDLE.

## Operation
- Per input: 2-flop synchronizer, then debouncer. The debounce counter is `$clog2(DEBOUNCE_CYCLES+1)` bits. It counts cycles where the synced value ≠ debounced level, clears on any match, and toggles the level when the count reaches `DEBOUNCE_CYCLES`.
- Press event: debounced rising edge, a one-cycle pulse `pl`/`pr`.
- FSM states: IDLE, WAIT_L, WAIT_R, EMIT_L, EMIT_R, EMIT_H, HOLDOFF.
- IDLE:
  - `pl`&`pr` → EMIT_H.
  - `pl` only → WAIT_L, window counter loaded with `PAIR_WINDOW`.
  - `pr` only → WAIT_R, window counter loaded with `PAIR_WINDOW`.
- WAIT_L: `pr` → EMIT_H. Otherwise the counter decrements, and → EMIT_L on the cycle it reaches 0. WAIT_R mirrors this.
- Releasing the first switch during WAIT does not cancel the request.
- EMIT_x → HOLDOFF after one cycle.
- HOLDOFF → IDLE once both debounced levels are 0. Press events are ignored in HOLDOFF.
- Outputs are registered and Moore-decoded:
  - EMIT_L: `left`=1.
  - EMIT_R: `right`=1.
  - EMIT_H: `left`=`right`=`hazard`=1.
  - All other states: outputs 0.
- `left`/`right` are never both high without `hazard`.

## Timing
- Reset values: all outputs 0, FSM in IDLE, debounced levels 0, all counters 0.
- Debounced edge: `DEBOUNCE_CYCLES`+2 edges after the raw change is first sampled.
- Paired or simultaneous press: outputs high in the cycle after edge `DEBOUNCE_CYCLES`+3.
- Single press: outputs high in the cycle after edge `DEBOUNCE_CYCLES`+3+`PAIR_WINDOW`.
- Second press on the last WAIT cycle (counter = 1) is still paired. Once the counter is 0 the request is single and the later press is ignored.
- Glitches shorter than `DEBOUNCE_CYCLES` cycles produce no event.
- Reset asserted mid-operation: everything returns to reset values immediately, with no pending request. A switch still held at deassertion is debounced from 0 and yields a fresh press.
- Every request pulse is exactly one cycle wide. At least 2 cycles separate consecutive pulses.

## Configuration
- `TBIRD_AUTOREPEAT_EN` defined: a repeat counter runs in HOLDOFF.
  - While the originating switch(es) remain debounced-high, the block re-enters the same EMIT state every `REPEAT_CYCLES` cycles, counted from the previous pulse.
  - Hazard repeats require both switches still high. If only one is still high, no repeat is issued and the block waits for release.
- `TBIRD_AUTOREPEAT_EN` undefined: no repeat counter exists, and exactly one pulse is issued per press.

## Structure
- `tbird_pkg`: state enum `cond_state_t`; default constants for the three parameters.
- Sub-module `tbird_debounce`: synchronizer, debounce counter, and rising-edge pulse. It is instantiated twice.
- Top level: pairing FSM, window counter, optional repeat counter, and output registers.

## Test plan
All scenarios use `DEBOUNCE_CYCLES`=4 and `PAIR_WINDOW`=8.
- Left held from cycle 0 → single `left` pulse at cycle 15; `right`=`hazard`=0; `busy` low after release + 6 cycles.
- Both held from cycle 0 → `left`=`right`=`hazard`=1 at cycle 7, exactly one cycle wide.
- Left at cycle 0, right at cycle 3 → hazard pulse at cycle 10.
- Right at cycle 0, left at cycle 9 (after the window) → `right` pulse at cycle 15; the left press is ignored.
- Left pulses of 3 cycles, repeated 5 times → no output.
- Reset asserted in WAIT_L with left still held → outputs 0 immediately; a new `left` pulse at cycle 15 after deassertion.
- With `TBIRD_AUTOREPEAT_EN` and `REPEAT_CYCLES`=64: left held → pulses at cycles 15, 79, 143.

Source files
------------

// File: rtl/tbird_pkg.sv
// Shared state type and default parameter values for the Thunderbird input conditioner.
package tbird_pkg;

   localparam int unsigned DEF_DEBOUNCE_CYCLES = 4;
   localparam int unsigned DEF_PAIR_WINDOW     = 8;
   localparam int unsigned DEF_REPEAT_CYCLES   = 64;

   typedef enum logic [2:0] {
      IDLE,
      WAIT_L,
      WAIT_R,
      EMIT_L,
      EMIT_R,
      EMIT_H,
      HOLDOFF
   } cond_state_t;

endpackage

// File: rtl/tbird_debounce.sv
// One switch channel: 2-flop synchronizer, stability-count debouncer and
// a one-cycle press pulse on the debounced rising edge.
module tbird_debounce
   import tbird_pkg::*;
#(
   parameter int unsigned DEBOUNCE_CYCLES = DEF_DEBOUNCE_CYCLES
) (
   input  logic clk,
   input  logic reset,
   input  logic raw,
   output logic level,
   output logic press
);

   localparam int unsigned CW = $clog2(DEBOUNCE_CYCLES + 1);

   logic          sync1;
   logic          sync2;
   logic          level_q;
   logic [CW-1:0] cnt;

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         sync1 <= 1'b0;
         sync2 <= 1'b0;
      end else begin
         sync1 <= raw;
         sync2 <= sync1;
      end
   end

   // The count sits at DEBOUNCE_CYCLES for one cycle; the level flips on the following edge.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         cnt   <= '0;
         level <= 1'b0;
      end else if (cnt == CW'(DEBOUNCE_CYCLES)) begin
         cnt   <= '0;
         level <= ~level;
      end else if (sync2 == level) begin
         cnt   <= '0;
      end else begin
         cnt   <= cnt + CW'(1);
      end
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         level_q <= 1'b0;
      end else begin
         level_q <= level;
      end
   end

   assign press = level & ~level_q;

endmodule

// File: rtl/tbird_input_cond.sv
// Pairs debounced left/right presses into single, hazard or (optionally
// repeated) one-cycle requests. Auto-repeat is built when TBIRD_AUTOREPEAT_EN is defined.
module tbird_input_cond
   import tbird_pkg::*;
#(
   parameter int unsigned DEBOUNCE_CYCLES = DEF_DEBOUNCE_CYCLES,
   parameter int unsigned PAIR_WINDOW     = DEF_PAIR_WINDOW,
   parameter int unsigned REPEAT_CYCLES   = DEF_REPEAT_CYCLES
) (
   input  logic clk,
   input  logic reset,
   input  logic left_raw,
   input  logic right_raw,
   output logic left,
   output logic right,
   output logic hazard,
   output logic busy
);

   localparam int unsigned WW = $clog2(PAIR_WINDOW + 1);

   if (DEBOUNCE_CYCLES < 1 || PAIR_WINDOW < 1 || REPEAT_CYCLES < 2) begin : g_param_check
      $error("tbird_input_cond: parameter out of range");
   end

   cond_state_t   state;
   cond_state_t   state_next;
   logic [WW-1:0] win_cnt;
   logic          lvl_l;
   logic          lvl_r;
   logic          pl;
   logic          pr;
   logic          left_d;
   logic          right_d;
   logic          hazard_d;
   logic          busy_d;

   tbird_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_deb_left (
      .clk   (clk),
      .reset (reset),
      .raw   (left_raw),
      .level (lvl_l),
      .press (pl)
   );

   tbird_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_deb_right (
      .clk   (clk),
      .reset (reset),
      .raw   (right_raw),
      .level (lvl_r),
      .press (pr)
   );

`ifdef TBIRD_AUTOREPEAT_EN
   localparam int unsigned RW = $clog2(REPEAT_CYCLES);

   logic [RW-1:0] rep_cnt;
   cond_state_t   origin;

   // Loaded on the EMIT cycle so that a count of 1 in HOLDOFF lands REPEAT_CYCLES after the pulse.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         rep_cnt <= '0;
         origin  <= IDLE;
      end else if (state inside {EMIT_L, EMIT_R, EMIT_H}) begin
         rep_cnt <= RW'(REPEAT_CYCLES - 1);
         origin  <= state;
      end else if (state == HOLDOFF && rep_cnt != '0) begin
         rep_cnt <= rep_cnt - RW'(1);
      end else if (state != HOLDOFF) begin
         rep_cnt <= '0;
      end
   end
`endif

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state <= IDLE;
      end else begin
         state <= state_next;
      end
   end

   always_comb begin
      state_next = state;
      case (state)
         IDLE: begin
            if (pl && pr)  state_next = EMIT_H;
            else if (pl)   state_next = WAIT_L;
            else if (pr)   state_next = WAIT_R;
         end
         WAIT_L: begin
            if (pr)                       state_next = EMIT_H;
            else if (win_cnt == WW'(1))   state_next = EMIT_L;
         end
         WAIT_R: begin
            if (pl)                       state_next = EMIT_H;
            else if (win_cnt == WW'(1))   state_next = EMIT_R;
         end
         EMIT_L, EMIT_R, EMIT_H: state_next = HOLDOFF;
         HOLDOFF: begin
            if (!lvl_l && !lvl_r) begin
               state_next = IDLE;
            end
`ifdef TBIRD_AUTOREPEAT_EN
            else if (rep_cnt == RW'(1)) begin
               case (origin)
                  EMIT_L:  if (lvl_l)          state_next = EMIT_L;
                  EMIT_R:  if (lvl_r)          state_next = EMIT_R;
                  EMIT_H:  if (lvl_l && lvl_r) state_next = EMIT_H;
                  default: state_next = HOLDOFF;
               endcase
            end
`endif
         end
         default: state_next = IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         win_cnt <= '0;
      end else if (state_next inside {WAIT_L, WAIT_R}) begin
         win_cnt <= (state == IDLE) ? WW'(PAIR_WINDOW) : win_cnt - WW'(1);
      end else begin
         win_cnt <= '0;
      end
   end

   // Outputs are decoded from the next state so they line up with the state register.
   always_comb begin
      left_d   = 1'b0;
      right_d  = 1'b0;
      hazard_d = 1'b0;
      busy_d   = (state_next != IDLE);
      case (state_next)
         EMIT_L:  left_d = 1'b1;
         EMIT_R:  right_d = 1'b1;
         EMIT_H: begin
            left_d   = 1'b1;
            right_d  = 1'b1;
            hazard_d = 1'b1;
         end
         default: ;
      endcase
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         left   <= 1'b0;
         right  <= 1'b0;
         hazard <= 1'b0;
         busy   <= 1'b0;
      end else begin
         left   <= left_d;
         right  <= right_d;
         hazard <= hazard_d;
         busy   <= busy_d;
      end
   end

endmodule

// File: tb/tb_tbird_input_cond.sv
// Scoreboard bench for tbird_input_cond: a request-level reference model queues
// expected pulses, a monitor compares them and busy every cycle.
module tb_tbird_input_cond;

   localparam int D = 4;
   localparam int W = 8;
   localparam int R = 64;

   logic clk = 1'b0;
   logic reset = 1'b0;
   logic left_raw = 1'b0;
   logic right_raw = 1'b0;
   logic left, right, hazard, busy;

   tbird_input_cond #(
      .DEBOUNCE_CYCLES (D),
      .PAIR_WINDOW     (W),
      .REPEAT_CYCLES   (R)
   ) dut (
      .clk       (clk),
      .reset     (reset),
      .left_raw  (left_raw),
      .right_raw (right_raw),
      .left      (left),
      .right     (right),
      .hazard    (hazard),
      .busy      (busy)
   );

   always #5 clk = ~clk;

   typedef struct {
      int   cyc;
      logic l;
      logic r;
      logic h;
   } pulse_t;

   pulse_t     exp_q[$];
   int         n_checks = 0;
   int         n_fail = 0;
   int         cyc = 0;
   logic       exp_busy = 1'b0;
   int         n_pulses = 0;
   int         last_pulse_cyc = -1;
   logic [2:0] last_kind = 3'b000;

   // Reference model state: raw sample history (bit j = sample j edges ago),
   // debounced levels, and the request in flight.
   bit [31:0] samp [2];
   bit        lvl [2];
   bit        rose [2];
   int        age [2];
   bit        pend = 0;
   int        pend_side = 0;
   int        deadline = 0;
   bit        locked = 0;
   int        emit_edge = 0;
   bit        em_l = 0, em_r = 0, em_h = 0;

   always @(posedge clk) begin : model
      bit emit;
      bit raw_now [2];
      bit new_rose [2];
      bit differs;
      cyc = cyc + 1;
      if (!reset) begin
         for (int s = 0; s < 2; s++) begin
            samp[s] = '0; lvl[s] = 0; rose[s] = 0; age[s] = 0;
         end
         pend = 0; locked = 0; exp_busy = 0;
         exp_q.delete();
      end else begin
         emit = 0;
         if (locked) begin
            if (cyc >= emit_edge + 2 && !lvl[0] && !lvl[1]) locked = 0;
`ifdef TBIRD_AUTOREPEAT_EN
            else if (cyc == emit_edge + R &&
                     (em_h ? (lvl[0] && lvl[1]) : (em_l ? lvl[0] : lvl[1]))) emit = 1;
`endif
         end else if (pend) begin
            if (rose[1 - pend_side]) begin
               emit = 1; em_l = 1; em_r = 1; em_h = 1;
            end else if (cyc == deadline) begin
               emit = 1; em_l = (pend_side == 0); em_r = (pend_side == 1); em_h = 0;
            end
         end else if (rose[0] && rose[1]) begin
            emit = 1; em_l = 1; em_r = 1; em_h = 1;
         end else if (rose[0] || rose[1]) begin
            pend = 1;
            pend_side = rose[0] ? 0 : 1;
            deadline = cyc + W;
         end
         if (emit) begin
            exp_q.push_back('{cyc: cyc, l: em_l, r: em_r, h: em_h});
            locked = 1;
            pend = 0;
            emit_edge = cyc;
         end
         exp_busy = locked || pend;

         // A level follows the switch once D consecutive synced samples disagree with it.
         raw_now[0] = left_raw;
         raw_now[1] = right_raw;
         for (int s = 0; s < 2; s++) begin
            samp[s] = {samp[s][30:0], raw_now[s]};
            age[s] = age[s] + 1;
            new_rose[s] = 0;
            differs = 1;
            for (int j = 3; j <= D + 2; j++)
               if (samp[s][j] == lvl[s]) differs = 0;
            if (age[s] >= D + 1 && differs) begin
               lvl[s] = !lvl[s];
               age[s] = 0;
               new_rose[s] = lvl[s];
            end
            rose[s] = new_rose[s];
         end
      end
   end

   always @(negedge clk) begin : monitor
      pulse_t e;
      n_checks++;
      if (busy !== exp_busy) begin
         n_fail++;
         $display("FAIL busy: got %b at cycle %0d, required %b", busy, cyc, exp_busy);
      end
      while (exp_q.size() > 0 && exp_q[0].cyc < cyc) begin
         e = exp_q.pop_front();
         n_checks++;
         n_fail++;
         $display("FAIL missed_pulse: got nothing by cycle %0d, required l/r/h=%b%b%b at cycle %0d",
                  cyc, e.l, e.r, e.h, e.cyc);
      end
      if (left || right || hazard) begin
         n_pulses++;
         last_pulse_cyc = cyc;
         last_kind = {left, right, hazard};
         n_checks++;
         if (exp_q.size() == 0) begin
            n_fail++;
            $display("FAIL unexpected_pulse: got l/r/h=%b%b%b at cycle %0d, required no pulse",
                     left, right, hazard, cyc);
         end else begin
            e = exp_q.pop_front();
            if (e.cyc != cyc || {e.l, e.r, e.h} != {left, right, hazard}) begin
               n_fail++;
               $display("FAIL pulse: got l/r/h=%b%b%b at cycle %0d, required %b%b%b at cycle %0d",
                        left, right, hazard, cyc, e.l, e.r, e.h, e.cyc);
            end
         end
      end
   end

   task automatic check(input string name, input int got, input int want);
      n_checks++;
      if (got != want) begin
         n_fail++;
         $display("FAIL %s: got %0d, required %0d", name, got, want);
      end
   endtask

   task automatic step();
      @(negedge clk);
      #1;
   endtask

   task automatic settle();
      step();
      left_raw = 0;
      right_raw = 0;
      repeat (30) step();
   endtask

   // Press one or both switches (second one after `gap` cycles), hold, release,
   // then verify pulse count, relative pulse cycle and pulse kind.
   task automatic press_case(input string name, input bit first_left, input bit use_second,
                             input int gap, input int hold, input int want_n,
                             input int want_rel, input int want_kind);
      int t0, p0;
      step();
      if (first_left) left_raw = 1; else right_raw = 1;
      t0 = cyc + 1;
      p0 = n_pulses;
      if (use_second) begin
         repeat (gap) step();
         if (first_left) right_raw = 1; else left_raw = 1;
      end
      repeat (hold) step();
      settle();
      check({name, "_count"}, n_pulses - p0, want_n);
      if (want_n > 0) begin
         check({name, "_cycle"}, last_pulse_cyc - t0, want_rel);
         check({name, "_kind"}, int'(last_kind), want_kind);
      end
   endtask

   initial begin : watchdog
      #500000;
      $display("FAIL watchdog: got simulation still running, required completion");
      $fatal(1, "timeout");
   end

   initial begin : stimulus
      int t0, p0, hl, hr;
      repeat (3) step();
      check("reset_outputs", int'({left, right, hazard, busy}), 0);
      reset = 1;
      repeat (5) step();

      press_case("single_left", 1, 0, 0, 25, 1, 15, 3'b100);
      press_case("both_same", 1, 1, 0, 25, 1, 7, 3'b111);
      press_case("left_then_right3", 1, 1, 3, 25, 1, 10, 3'b111);
      press_case("right_then_left9", 0, 1, 9, 25, 1, 15, 3'b010);
      press_case("pair_last_wait", 1, 1, 8, 25, 1, 15, 3'b111);
      press_case("pair_too_late", 1, 1, 9, 25, 1, 15, 3'b100);

      // Short glitches must never be debounced into a press.
      p0 = n_pulses;
      for (int g = 0; g < 5; g++) begin
         step();
         left_raw = 1;
         repeat (3) step();
         left_raw = 0;
         repeat (3) step();
      end
      settle();
      check("glitch_count", n_pulses - p0, 0);

      // Reset in the middle of the pairing window with the switch still held.
      step();
      left_raw = 1;
      p0 = n_pulses;
      repeat (10) step();
      reset = 0;
      #1;
      check("reset_mid_outputs", int'({left, right, hazard, busy}), 0);
      repeat (3) step();
      reset = 1;
      t0 = cyc + 1;
      repeat (25) step();
      settle();
      check("reset_mid_count", n_pulses - p0, 1);
      check("reset_mid_cycle", last_pulse_cyc - t0, 15);

`ifdef TBIRD_AUTOREPEAT_EN
      press_case("autorepeat_left", 1, 0, 0, 150, 3, 143, 3'b100);
`endif

      // Random independent switch activity, from glitches to long holds.
      hl = 1;
      hr = 1;
      for (int i = 0; i < 600; i++) begin
         step();
         hl--;
         hr--;
         if (hl <= 0) begin
            left_raw = !left_raw;
            hl = $urandom_range(14, 1);
         end
         if (hr <= 0) begin
            right_raw = !right_raw;
            hr = $urandom_range(14, 1);
         end
      end
      settle();

      check("queue_drained", exp_q.size(), 0);
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
